branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/cpu_pkg.sv | 19 +
 rtl/branch_cond_eval.sv | 40 ++++
 rtl/branch_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the branch sequencer: branch opcodes, sequencer states
// and the bit positions of the Z/N flags.
package cpu_pkg;

  localparam logic [4:0] OP_BEQ = 5'b10011;
  localparam logic [4:0] OP_BLT = 5'b10100;
  localparam logic [4:0] OP_BGT = 5'b10101;
  localparam logic [4:0] OP_BNE = 5'b10110;

  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FLUSH = 2'b10
  } seq_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch decoder: flags an opcode as a conditional branch
// and evaluates its taken condition against {Z, N}.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] flags,
  output logic       is_branch,
  output logic       taken
);

  // Decode opcode and evaluate taken condition
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    case (opcode)
      OP_BEQ: begin
        is_branch = 1'b1;
        taken     = flags[FLAG_Z];
      end
      OP_BNE: begin
        is_branch = 1'b1;
        taken     = ~flags[FLAG_Z];
      end
      OP_BLT: begin
        is_branch = 1'b1;
        taken     = flags[FLAG_N];
      end
      OP_BGT: begin
        is_branch = 1'b1;
        taken     = ~flags[FLAG_N];
      end
      default: begin
        is_branch = 1'b0;
        taken     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Sequences a conditional branch: captures it, waits for valid flags, resolves
// it, and on a taken branch redirects the PC and holds flush for FLUSH_CYCLES.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [4:0]        opcode,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [1:0]        flags,
  input  logic              flags_valid,
  output logic              stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic              br_done,
  output logic              br_taken
);

  seq_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              done_d, taken_d, redirect_d;

  logic              stall_q, flush_q, pc_redirect_q, br_done_q, br_taken_q;
  logic [ADDR_W-1:0] pc_target_q;

  logic [4:0]        eval_op_s;
  logic              is_branch_s, cond_taken_s;

  // The single evaluator decodes the live opcode in IDLE and the latched one otherwise
  assign eval_op_s = (state_q == ST_IDLE) ? opcode : op_q;

  branch_cond_eval u_cond (
    .opcode    (eval_op_s),
    .flags     (flags),
    .is_branch (is_branch_s),
    .taken     (cond_taken_s)
  );

  // Next-state, capture and resolution logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    done_d     = 1'b0;
    taken_d    = 1'b0;
    redirect_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid && is_branch_s) begin
          op_d    = opcode;
          tgt_d   = br_target;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flags_valid) begin
          done_d  = 1'b1;
          taken_d = cond_taken_s;
          if (cond_taken_s) begin
            state_d    = ST_FLUSH;
            cnt_d      = 4'(FLUSH_CYCLES - 1);
            redirect_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      op_q          <= 5'd0;
      tgt_q         <= {ADDR_W{1'b0}};
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= {ADDR_W{1'b0}};
      br_done_q     <= 1'b0;
      br_taken_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      tgt_q         <= tgt_d;
      stall_q       <= (state_d != ST_IDLE);
      flush_q       <= (state_d == ST_FLUSH);
      pc_redirect_q <= redirect_d;
      pc_target_q   <= redirect_d ? tgt_q : {ADDR_W{1'b0}};
      br_done_q     <= done_d;
      br_taken_q    <= taken_d;
    end
  end

  assign stall       = stall_q;
  assign flush       = flush_q;
  assign pc_redirect = pc_redirect_q;
  assign pc_target   = pc_target_q;
  assign br_done     = br_done_q;
  assign br_taken    = br_taken_q;

endmodule
